// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the uart_tx arbiter and its benches
package uart_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, HOLD} arb_state_t;
  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       last;
  } uart_tx_req_t;
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin selector starting at ptr
module uart_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic                 found
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] j;
  // walk from farthest to nearest so the requester closest to ptr wins
  always_comb begin
    grant = '0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = PW'((int'(ptr) + i) % N);
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
      end
    end
  end
  assign found = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin per-message sharing of one uart_tx among NUM_REQ producers
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_lock_abort,
  output logic [DATA_WIDTH-1:0]         o_tx_din,
  output logic                          o_tx_valid,
  input  logic                          i_tx_busy
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  arb_state_t state;
  logic [PW-1:0] ptr, g_idx, pick_idx, ptr_nxt;
  logic [CW-1:0] cnt;
  logic [NUM_REQ-1:0] pick;
  logic last_q, found, gv, timeout;
  uart_rr_pick #(.N(NUM_REQ)) u_pick (
    .req  (i_req_valid),
    .ptr  (ptr),
    .grant(pick),
    .found(found)
  );
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) pick_idx = pick[i] ? PW'(i) : pick_idx;
  end
  assign gv = i_req_valid[g_idx];
  assign timeout = state == HOLD && !gv && cnt == CW'(LOCK_TIMEOUT);
  assign ptr_nxt = g_idx == PW'(NUM_REQ - 1) ? '0 : g_idx + 1'b1;
  assign o_tx_valid = state == LAUNCH;
  assign o_req_ready = o_tx_valid ? o_grant : '0;
  assign o_lock_abort = timeout;
  assign o_tx_din = |o_grant ? i_req_data[g_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  // IDLE also waits out a frame still in flight from before a reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      ptr     <= '0;
      g_idx   <= '0;
      last_q  <= 1'b0;
      cnt     <= '0;
      o_grant <= '0;
    end else begin
      case (state)
        IDLE: if (!i_tx_busy && found) begin
          o_grant <= pick;
          g_idx   <= pick_idx;
          state   <= LAUNCH;
        end
        LAUNCH: begin
          last_q <= i_req_last[g_idx];
          state  <= WAIT_BUSY;
        end
        WAIT_BUSY: if (i_tx_busy) state <= WAIT_DONE;
        WAIT_DONE: if (!i_tx_busy) begin
          cnt <= '0;
          if (last_q) begin
            o_grant <= '0;
            ptr     <= ptr_nxt;
            state   <= IDLE;
          end else state <= gv ? LAUNCH : HOLD;
        end
        HOLD: if (gv) begin
          cnt   <= '0;
          state <= LAUNCH;
        end else if (timeout) begin
          o_grant <= '0;
          ptr     <= ptr_nxt;
          state   <= IDLE;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with a frame-level uart_tx busy model and launch/abort scoreboard
module tb_uart_tx_arbiter;
  import uart_pkg::*;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int LT = 16;
  localparam int FRAME = 12;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic [NR*DW-1:0] i_req_data = '0;
  logic [NR-1:0] i_req_valid = '0;
  logic [NR-1:0] i_req_last = '0;
  logic [NR-1:0] o_req_ready, o_grant;
  logic o_lock_abort, o_tx_valid;
  logic [DW-1:0] o_tx_din;
  logic i_tx_busy = 1'b0;

  uart_tx_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .LOCK_TIMEOUT(LT)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_data  (i_req_data),
    .i_req_valid (i_req_valid),
    .i_req_last  (i_req_last),
    .o_req_ready (o_req_ready),
    .o_grant     (o_grant),
    .o_lock_abort(o_lock_abort),
    .o_tx_din    (o_tx_din),
    .o_tx_valid  (o_tx_valid),
    .i_tx_busy   (i_tx_busy)
  );

  always #20 i_clk = ~i_clk;

  typedef struct {
    int         req;
    logic [7:0] data;
    int         gap;
  } exp_t;

  exp_t exp_l[$];
  exp_t exp_a[$];
  exp_t e_l, e_a;
  uart_tx_req_t q[NR][$];
  logic [7:0] rx[$];
  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int aborts = 0;
  int bcnt = 0;
  logic prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // uart_tx stand-in: busy rises the edge after a launch and lasts FRAME clocks; never reset by i_rst
  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (o_tx_valid && !i_tx_busy) begin
      i_tx_busy <= 1'b1;
      bcnt <= FRAME;
      rx.push_back(o_tx_din);
    end else if (i_tx_busy) begin
      if (bcnt == 1) i_tx_busy <= 1'b0;
      bcnt <= bcnt - 1;
    end
  end

  always @(negedge i_clk) begin
    if (!i_rst) begin
      chk("grant_onehot", 32'($countones(o_grant) <= 1), 1);
      if (o_grant == '0) chk("din_idle", o_tx_din, 0);
      if (o_tx_valid) begin
        if (exp_l.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_launch: got grant %0h din %0h expected no launch", o_grant, o_tx_din);
        end else begin
          e_l = exp_l.pop_front();
          chk("launch_ready", o_req_ready, 1 << e_l.req);
          chk("launch_grant", o_grant, 1 << e_l.req);
          chk("launch_din", o_tx_din, e_l.data);
          chk("launch_busy", i_tx_busy, 0);
          if (e_l.gap >= 0) chk("launch_gap", cyc - fall_cyc, e_l.gap);
        end
      end else chk("ready_idle", o_req_ready, 0);
      if (o_lock_abort) begin
        aborts++;
        if (exp_a.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_abort: got abort with grant %0h expected none", o_grant);
        end else begin
          e_a = exp_a.pop_front();
          chk("abort_grant", o_grant, 1 << e_a.req);
          chk("abort_gap", cyc - fall_cyc, e_a.gap);
        end
      end
      if (prev_busy && !i_tx_busy) fall_cyc = cyc;
      prev_busy = i_tx_busy;
    end
  end

  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      i_req_valid[k] = q[k].size() > 0;
      i_req_data[k*DW +: DW] = q[k].size() > 0 ? q[k][0].data : 8'hC0 | 8'(k);
      i_req_last[k] = q[k].size() > 0 && q[k][0].last;
    end
  endtask

  task automatic tick();
    logic [NR-1:0] rdy;
    @(negedge i_clk);
    rdy = o_req_ready;
    @(posedge i_clk);
    #1;
    for (int k = 0; k < NR; k++) if (rdy[k] && q[k].size() > 0) q[k].delete(0);
    drive();
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l);
    uart_tx_req_t r;
    r.data = d;
    r.valid = 1'b1;
    r.last = l;
    q[k].push_back(r);
  endtask

  task automatic exp_launch(input int k, input logic [7:0] d, input int gap);
    exp_t e;
    e.req = k;
    e.data = d;
    e.gap = gap;
    exp_l.push_back(e);
  endtask

  function automatic bit all_quiet();
    for (int k = 0; k < NR; k++) if (q[k].size() > 0) return 1'b0;
    return !i_tx_busy && o_grant == '0 && exp_l.size() == 0 && exp_a.size() == 0;
  endfunction

  task automatic wait_idle(input string name);
    int stable = 0;
    for (int t = 0; t < 300 && stable < 3; t++) begin
      tick();
      stable = all_quiet() ? stable + 1 : 0;
    end
    if (stable < 3) begin
      vectors++;
      errors++;
      $display("FAIL %s_idle: got pending work after 300 cycles expected quiet", name);
    end
    chk({name, "_grant_released"}, o_grant, 0);
  endtask

  task automatic wait_launch(input string name);
    int t = 0;
    while (!o_tx_valid && t < 100) begin
      tick();
      t++;
    end
    if (!o_tx_valid) begin
      vectors++;
      errors++;
      $display("FAIL %s_launch: got no o_tx_valid in 100 cycles expected a launch", name);
    end
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_grant"}, o_grant, 0);
    chk({name, "_ready"}, o_req_ready, 0);
    chk({name, "_tx_valid"}, o_tx_valid, 0);
    chk({name, "_abort"}, o_lock_abort, 0);
    chk({name, "_din"}, o_tx_din, 0);
  endtask

  initial begin
    logic [7:0] lit [11] = '{8'hA6, 8'h11, 8'h33, 8'h01, 8'h02, 8'h03, 8'hFF, 8'h55, 8'h00, 8'h5A, 8'h37};
    exp_t ea;
    drive();
    repeat (3) tick();
    chk_reset("reset");
    i_rst = 1'b0;

    push(0, 8'hA6, 1'b1);
    exp_launch(0, 8'hA6, -1);
    drive();
    wait_idle("single");

    push(1, 8'h11, 1'b1);
    push(3, 8'h33, 1'b1);
    exp_launch(1, 8'h11, -1);
    exp_launch(3, 8'h33, 2);
    drive();
    wait_idle("contention");

    push(2, 8'h01, 1'b0);
    push(2, 8'h02, 1'b0);
    push(2, 8'h03, 1'b1);
    exp_launch(2, 8'h01, -1);
    exp_launch(2, 8'h02, 1);
    exp_launch(2, 8'h03, 1);
    exp_launch(0, 8'hFF, 2);
    drive();
    wait_launch("locked");
    push(0, 8'hFF, 1'b1);
    drive();
    wait_idle("locked");

    // abort lands LT+1 clocks after busy falls; req0 launches two clocks after that
    push(1, 8'h55, 1'b0);
    exp_launch(1, 8'h55, -1);
    ea.req = 1;
    ea.data = 8'h00;
    ea.gap = LT + 1;
    exp_a.push_back(ea);
    exp_launch(0, 8'h00, LT + 3);
    drive();
    wait_launch("timeout");
    push(0, 8'h00, 1'b1);
    drive();
    wait_idle("timeout");
    chk("abort_count", aborts, 1);

    push(2, 8'h5A, 1'b0);
    exp_launch(2, 8'h5A, -1);
    drive();
    wait_launch("midframe");
    push(3, 8'h37, 1'b1);
    drive();
    repeat (4) tick();
    chk("midframe_busy", i_tx_busy, 1);
    i_rst = 1'b1;
    tick();
    chk_reset("midframe_reset");
    i_rst = 1'b0;
    exp_launch(3, 8'h37, 1);
    wait_idle("midframe");
    chk("abort_count_final", aborts, 1);

    chk("rx_count", rx.size(), 11);
    for (int i = 0; i < 11 && i < rx.size(); i++) chk($sformatf("rx_byte%0d", i), rx[i], lit[i]);
    chk("launches_left", exp_l.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` instance among `NUM_REQ` byte producers (e.g. console, debug logger, status reporter). It performs round-robin arbitration per message. A message is one or more bytes terminated by `last`. The arbiter launches each byte into `uart_tx` with a single-cycle valid pulse and tracks the transmitter's busy flag until the frame completes. A stalled message is released after a timeout.

## Interface
Parameters:
- `DATA_WIDTH`, 8: byte width; must match `uart_tx`.
- `NUM_REQ`, 4: number of requesters, 2..8.
- `LOCK_TIMEOUT`, 4096: clocks a locked requester may leave `valid` low between bytes before its lock is dropped; minimum 1.

Ports:
- `i_clk`, in, 1: system clock.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_req_data`, in, `NUM_REQ*DATA_WIDTH`: requester k's byte sits at bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `i_req_valid`, in, `NUM_REQ`: per-requester byte available.
- `i_req_last`, in, `NUM_REQ`: marks the final byte of a message; qualified by valid.
- `o_req_ready`, out, `NUM_REQ`: byte accepted this cycle.
- `o_grant`, out, `NUM_REQ`: one-hot current owner; all zero when none.
- `o_lock_abort`, out, 1: 1-cycle pulse when a lock times out.
- `o_tx_din`, out, `DATA_WIDTH`: connects to `uart_tx` `i_din`.
- `o_tx_valid`, out, 1: connects to `uart_tx` `i_valid`.
- `i_tx_busy`, in, 1: connects to `uart_tx` `o_busy`.

## Operation
- Requester rules:
  - Valid, data and last are held stable from assertion until ready is seen.
  - Valid never depends on ready.
  - A transfer occurs on a cycle with valid & ready both high.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, HOLD.
  - IDLE:
    - If `!i_tx_busy` and any valid is high, the winner is chosen round-robin.
    - Priority order starts at `ptr`, then `ptr+1` and onward, mod `NUM_REQ`.
    - The winner is registered into `o_grant`, and the FSM goes to LAUNCH.
    - If `i_tx_busy` is high, the FSM stays in IDLE. This covers an arbiter reset while `uart_tx` is still sending.
  - LAUNCH (exactly 1 cycle):
    - `o_tx_valid`=1.
    - `o_req_ready[g]`=1, where g is the granted requester.
    - `o_tx_din` = data of g.
    - The `last` bit of g is latched into `last_q`.
    - Next state is WAIT_BUSY.
  - WAIT_BUSY: stays until `i_tx_busy`=1, then goes to WAIT_DONE.
  - WAIT_DONE: stays until `i_tx_busy`=0.
    - If `last_q`=1: grant is released, `ptr` becomes g+1 mod `NUM_REQ`, and the FSM goes to IDLE.
    - Otherwise: goes to LAUNCH if valid of g is high, else to HOLD.
  - HOLD: grant is kept and the timeout counter runs.
    - If valid of g is high, the FSM goes to LAUNCH and the counter clears.
    - If the counter reaches `LOCK_TIMEOUT`: `o_lock_abort` pulses, the grant is released, `ptr` becomes g+1, and the FSM goes to IDLE.
    - The abandoned requester's next byte competes as a new message.
- `o_tx_din` is 0 whenever `o_grant` is 0. Otherwise it follows the granted slice combinationally.
- Requests that arrive while another requester is granted wait; they are never dropped.
- A `last` asserted on a single-byte message releases the grant after that byte.

## Timing
- Reset values:
  - State IDLE, `ptr`=0, `last_q`=0, timeout counter 0.
  - `o_grant`=0, `o_req_ready`=0, `o_tx_valid`=0, `o_lock_abort`=0, `o_tx_din`=0.
- Reset in any state returns to IDLE on the next edge. Any partial message is abandoned with no abort pulse.
- Valid seen in IDLE at cycle n → LAUNCH at n+1 (`o_tx_valid`, ready) → `i_tx_busy` rises at n+2.
- Back-to-back bytes of a locked message: the next LAUNCH comes 1 cycle after `i_tx_busy` falls.
- Requester switch: `busy` falls → IDLE → LAUNCH, a 2-cycle gap.
- `o_tx_valid` is never asserted while `i_tx_busy`=1.
- There is at most one `o_req_ready` bit per cycle, and it is set only in LAUNCH.
- Timeout counter width is `$clog2(LOCK_TIMEOUT+1)` and it saturates. The abort fires on the cycle the count equals `LOCK_TIMEOUT`.

## Structure
- `uart_pkg` holds:
  - the FSM state enum typedef, `arb_state_t`;
  - a `uart_tx_req_t` struct (`data`, `valid`, `last`), used by benches.
- Sub-module `uart_rr_pick`: a combinational round-robin selector. Inputs are the request vector and `ptr`; outputs are the one-hot winner and a `found` flag.

## Test plan
Bench setup: real `uart_baudgen` + `uart_tx` + reference receiver, 25 MHz clock, 115200 baud, `NUM_REQ`=4.
- Single request: req0 sends 0xA6 with last=1. Expect ready exactly once, the receiver reads 0xA6, and the grant returns to 0 after busy falls.
- Contention: req1 and req3 each send a 1-byte message in the same cycle with `ptr`=0. Expect order 0x11 (req1) then 0x33 (req3); `ptr` ends at 0.
- Locked message: req2 sends 0x01, 0x02, 0x03 (last on 0x03) while req0 holds valid with 0xFF. Expect the receiver order to be 01, 02, 03, FF.
- Lock timeout: `LOCK_TIMEOUT`=16; req1 sends 0x55 with last=0, then drops valid. Expect `o_lock_abort` 16 clocks into HOLD, then req0's pending 0x00 is sent next.
- Reset mid-frame: assert `i_rst` during WAIT_DONE while `uart_tx` is not reset. Expect all outputs to reach their reset values and no `o_tx_valid` until busy falls; a pending 0x37 then sends correctly.
